banked_mem_pipe: RTL



---
 rtl/banked_mem_pipe.sv | 108 ++++++++++
 1 files changed

// File: rtl/banked_mem_pipe.sv
// Four-bank word-interleaved main memory with a 2-stage read pipeline and per-bank busy windows.
// Optional BANK_CONFLICT_CNT_EN adds a saturating count of stalled cycles on conflict_cnt.
module banked_mem_pipe #(
    parameter int ADDR_W   = 16,
    parameter int BUSY_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [15:0]       data_out,
    output logic              data_valid,
    output logic              stall,
    output logic [3:0]        busy,
`ifdef BANK_CONFLICT_CNT_EN
    output logic [15:0]       conflict_cnt,
`endif
    output logic              err
);

    localparam int         DEPTH     = 1 << (ADDR_W - 3);
    localparam logic [2:0] BUSY_LOAD = 3'(BUSY_CYC - 1);

    logic [1:0]        bank_sel;
    logic [ADDR_W-4:0] word_idx;
    logic              req;
    logic              accept;

    assign bank_sel = addr[2:1];
    assign word_idx = addr[ADDR_W-1:3];
    assign req      = rd | wr;
    assign err      = (rd & wr) | (req & addr[0]);
    assign stall    = req & ~err & busy[bank_sel];
    assign accept   = req & ~err & ~busy[bank_sel];

    logic [3:0][15:0] bank_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [15:0] mem [DEPTH];
            logic [15:0] q_reg;
            logic [2:0]  cnt_reg;
            logic        hit;

            assign hit = accept & (bank_sel == 2'(gi));

            // Storage is deliberately left out of reset so it maps onto block RAM.
            always_ff @(posedge clk) begin
                if (hit & wr)
                    mem[word_idx] <= data_in;
                if (hit & rd)
                    q_reg <= mem[word_idx];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg <= 3'd0;
                else if (hit)
                    cnt_reg <= BUSY_LOAD;
                else if (cnt_reg != 3'd0)
                    cnt_reg <= cnt_reg - 3'd1;
            end

            assign busy[gi]   = (cnt_reg != 3'd0);
            assign bank_q[gi] = q_reg;
        end
    endgenerate

    // Stage 1 tracks which bank is producing the word; stage 2 drives the output.
    logic        s1_valid_reg;
    logic [1:0]  s1_bank_reg;
    logic        data_valid_reg;
    logic [15:0] data_out_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_bank_reg    <= 2'd0;
            data_valid_reg <= 1'b0;
            data_out_reg   <= 16'h0000;
        end else begin
            s1_valid_reg   <= accept & rd;
            s1_bank_reg    <= bank_sel;
            data_valid_reg <= s1_valid_reg;
            data_out_reg   <= s1_valid_reg ? bank_q[s1_bank_reg] : 16'h0000;
        end
    end

    assign data_valid = data_valid_reg;
    assign data_out   = data_out_reg;

`ifdef BANK_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflict_cnt_reg <= 16'h0000;
        else if (stall && (conflict_cnt_reg != 16'hFFFF))
            conflict_cnt_reg <= conflict_cnt_reg + 16'h0001;
    end

    assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule
